// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR: circular sample history, one MAC per cycle,
// rounded and saturated output per accepted input sample.
module fir_mac_seq #(
  parameter int TAPS      = 512,
  parameter int AW        = 9,
  parameter int DW        = 24,
  parameter int CW        = 35,
  parameter int OUT_SHIFT = 34
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int PW  = DW + CW;
  localparam int ACW = PW + AW;

  localparam logic signed [ACW-1:0] RND  = ACW'(1) << (OUT_SHIFT - 1);
  localparam logic signed [ACW-1:0] MAXV = ACW'((1 << (DW - 1)) - 1);
  localparam logic signed [ACW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [AW-1:0] r_clr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_saddr;
  logic [AW-1:0] r_caddr;
  logic [1:0]    r_dcnt;
  logic          r_busy;
  logic          r_ovr;
  logic          r_dv;
  logic          r_v1;
  logic          r_v2;
  logic [DW-1:0] r_dout;

  logic signed [DW-1:0]  r_samp;
  logic signed [PW-1:0]  r_prod;
  logic signed [ACW-1:0] r_acc;
  logic [DW-1:0]         r_mem [TAPS];

  logic                  w_accept;
  logic                  w_last_tap;
  logic                  w_drain_done;
  logic                  w_clr_we;
  logic signed [ACW-1:0] w_rnd;
  logic signed [ACW-1:0] w_sh;
  logic [DW-1:0]         w_sat;

  assign w_accept     = (r_state == S_IDLE) && din_valid;
  assign w_last_tap   = (r_caddr == AW'(TAPS - 1));
  assign w_drain_done = (r_dcnt == 2'd2);
  // first cycle after reset only arms busy; the TAPS clear writes follow
  assign w_clr_we     = (r_state == S_CLEAR) && r_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_CLEAR;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_CLEAR: if (r_busy && r_clr == AW'(TAPS - 1)) w_next = S_IDLE;
      S_IDLE:  if (din_valid) w_next = S_RUN;
      S_RUN:   if (w_last_tap) w_next = S_DRAIN;
      S_DRAIN: if (w_drain_done) w_next = S_IDLE;
      default: w_next = S_CLEAR;
    endcase
  end

  always_comb begin
    w_rnd = r_acc + RND;
    w_sh  = w_rnd >>> OUT_SHIFT;
    if (w_sh > MAXV)      w_sat = DW'(MAXV);
    else if (w_sh < MINV) w_sat = DW'(MINV);
    else                  w_sat = DW'(w_sh);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_ovr    <= 1'b0;
      r_clr    <= '0;
      r_wr_ptr <= '0;
      r_saddr  <= '0;
      r_caddr  <= '0;
      r_dcnt   <= '0;
      r_dv     <= 1'b0;
      r_dout   <= '0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_acc    <= '0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      if (r_busy && din_valid) r_ovr <= 1'b1;
      if (w_clr_we) r_clr <= r_clr + 1'b1;
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_saddr  <= r_wr_ptr;
        r_caddr  <= '0;
      end else if (r_state == S_RUN && !w_last_tap) begin
        r_caddr <= r_caddr + 1'b1;
        r_saddr <= r_saddr - 1'b1;
      end
      r_dcnt <= (r_state == S_DRAIN) ? r_dcnt + 2'd1 : 2'd0;
      r_dv   <= (r_state == S_DRAIN) && w_drain_done;
      if ((r_state == S_DRAIN) && w_drain_done) r_dout <= w_sat;
      r_v1 <= (r_state == S_RUN);
      r_v2 <= r_v1;
      if (w_accept)  r_acc <= '0;
      else if (r_v2) r_acc <= r_acc + {{AW{r_prod[PW-1]}}, r_prod};
    end
  end

  // history RAM plus the two datapath pipeline registers
  always_ff @(posedge clk) begin
    if (w_clr_we)      r_mem[r_clr]    <= '0;
    else if (w_accept) r_mem[r_wr_ptr] <= din;
    r_samp <= $signed(r_mem[r_saddr]);
    r_prod <= r_samp * $signed(coef_data);
  end

  assign coef_addr  = r_caddr;
  assign dout       = r_dout;
  assign dout_valid = r_dv;
  assign busy       = r_busy;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: ROM model, history model and an expected-output
// queue popped on every dout_valid.
module tb_fir_mac_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] din = '0;
  logic        din_valid = 1'b0;
  logic [8:0]  coef_addr;
  logic [34:0] coef_data = '0;
  logic [23:0] dout;
  logic        dout_valid;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  fir_mac_seq dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .din_valid(din_valid),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .dout(dout),
    .dout_valid(dout_valid),
    .busy(busy),
    .overrun(overrun)
  );

  typedef struct {
    logic [23:0] d;
    logic [34:0] c0;
    logic [23:0] e;
  } vec_t;

  logic [34:0] rom  [512];
  logic [23:0] hist [512];
  logic [23:0] exp_q [$];
  int wp = 0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_dv = 0;
  int last_dv = 0;
  int t_send = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    coef_data <= rom[coef_addr];
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      n_dv++;
      last_dv = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_dout", {40'd0, dout}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("dout", {40'd0, dout}, {40'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [23:0] model(input int nw);
    logic signed [67:0] a;
    logic signed [67:0] p;
    a = '0;
    for (int k = 0; k < 512; k++) begin
      p = 68'($signed(hist[(nw - k) & 511])) * 68'($signed(rom[k]));
      a = a + p;
    end
    a = (a + 68'sd8589934592) >>> 34;
    if (a > 68'sd8388607) return 24'h7FFFFF;
    if (a < -68'sd8388608) return 24'h800000;
    return a[23:0];
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) begin
      chk("output_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic drive(input logic [23:0] x);
    @(posedge clk);
    #1;
    wait_idle();
    din = x;
    din_valid = 1'b1;
    t_send = cyc;
    hist[wp] = x;
  endtask

  task automatic release_in();
    wp = (wp + 1) & 511;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic send_e(input logic [23:0] x, input logic [23:0] e);
    drive(x);
    exp_q.push_back(e);
    release_in();
  endtask

  task automatic send_m(input logic [23:0] x);
    drive(x);
    exp_q.push_back(model(wp));
    release_in();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 512; i++) hist[i] = '0;
    wp = 0;
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_idle();
  endtask

  task automatic rom_fill(input logic [34:0] v);
    for (int k = 0; k < 512; k++) rom[k] = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: cyc=%0d", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [12];
    int nb;
    int nq;
    int dv0;

    tv[0]  = '{24'h123456, 35'h3FFFFFFFF, 24'h123456};
    tv[1]  = '{24'hFFFFFF, 35'h3FFFFFFFF, 24'hFFFFFF};
    tv[2]  = '{24'h7FFFFF, 35'h3FFFFFFFF, 24'h7FFFFF};
    tv[3]  = '{24'h800000, 35'h3FFFFFFFF, 24'h800000};
    tv[4]  = '{24'h000003, 35'h200000000, 24'h000002};
    tv[5]  = '{24'hFFFFFD, 35'h200000000, 24'hFFFFFF};
    tv[6]  = '{24'h000001, 35'h200000000, 24'h000001};
    tv[7]  = '{24'hFFFFFF, 35'h200000000, 24'h000000};
    tv[8]  = '{24'h000003, 35'h600000000, 24'hFFFFFF};
    tv[9]  = '{24'h000002, 35'h600000000, 24'hFFFFFF};
    tv[10] = '{24'h800000, 35'h600000000, 24'h400000};
    tv[11] = '{24'h000000, 35'h3FFFFFFFF, 24'h000000};

    rom_fill('0);
    for (int i = 0; i < 512; i++) hist[i] = '0;

    // reset and CLEAR window
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {busy, dout_valid, overrun, dout, coef_addr}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nb = 0;
    nq = 0;
    repeat (600) begin
      @(negedge clk);
      if (busy) nb++;
      if (dout !== '0 || dout_valid !== 1'b0 || overrun !== 1'b0) nq++;
    end
    chk("clear_busy_cycles", 64'(nb), 64'd512);
    chk("clear_outs_quiet", 64'(nq), 64'd0);
    chk("idle_after_clear", {63'd0, busy}, 64'd0);

    // single-tap vectors: identity, rounding, sign, negative coefficient
    for (int i = 0; i < 12; i++) begin
      rom[0] = tv[i].c0;
      send_e(tv[i].d, tv[i].e);
      wait_done();
      if (i == 0) chk("latency", 64'(last_dv - t_send), 64'd516);
    end

    // impulse response, back-to-back (next input in the dout_valid cycle)
    do_reset();
    for (int k = 0; k < 512; k++) rom[k] = 35'(k) << 12;
    send_e(24'h400000, 24'd0);
    for (int n = 1; n < 16; n++) send_e(24'h000000, 24'(n));
    wait_done();
    chk("latency_b2b", 64'(last_dv - t_send), 64'd516);

    // saturation both ways from a clean history
    do_reset();
    rom_fill(35'h3FFFFFFFF);
    repeat (3) send_e(24'h7FFFFF, 24'h7FFFFF);
    wait_done();
    do_reset();
    repeat (3) send_e(24'h800000, 24'h800000);
    wait_done();

    // dropped sample during RUN
    do_reset();
    for (int k = 0; k < 512; k++) rom[k] = 35'(k + 1) << 20;
    chk("overrun_clear", {63'd0, overrun}, 64'd0);
    send_m(24'h001000);
    repeat (10) @(posedge clk);
    #1;
    din = 24'h7ABCDE;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    chk("overrun_set", {63'd0, overrun}, 64'd1);
    wait_done();
    send_m(24'h000100);
    wait_done();
    chk("overrun_sticky", {63'd0, overrun}, 64'd1);

    // abort mid-RUN, then confirm the history restarts from zero
    do_reset();
    rom_fill(35'h040000000);
    send_m(24'h300000);
    send_m(24'h200000);
    wait_done();
    @(posedge clk);
    #1;
    wait_idle();
    din = 24'h111111;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    repeat (50) @(posedge clk);
    dv0 = n_dv;
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_dout", 64'(n_dv - dv0), 64'd0);
    chk("abort_ovr_clr", {63'd0, overrun}, 64'd0);
    send_e(24'h100000, 24'h010000);
    wait_done();
    rom_fill('0);
    rom[0] = 35'h3FFFFFFFF;
    send_e(24'h123456, 24'h123456);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
